// File: rtl/tilemap_scheduler_if.sv
// Map RAM read port and tile drawer handshake for the tilemap scheduler.
interface tilemap_scheduler_if;
  logic [8:0] map_addr;
  logic [7:0] map_data;
  logic [7:0] drawer_tile_address;
  logic [7:0] drawer_x;
  logic [7:0] drawer_y;
  logic       drawer_draw;
  logic       drawer_active;

  modport master (
    output map_addr,
    input  map_data,
    output drawer_tile_address,
    output drawer_x,
    output drawer_y,
    output drawer_draw,
    input  drawer_active
  );

  modport slave (
    input  map_addr,
    output map_data,
    input  drawer_tile_address,
    input  drawer_x,
    input  drawer_y,
    input  drawer_draw,
    output drawer_active
  );
endinterface

// File: rtl/tilemap_scheduler.sv
// Walks the tile map row by row, reads each entry from a synchronous map RAM
// and hands every drawable tile to the tile drawer, one tile at a time.
// Coordinates are produced at 8 bits, so MAP_COLS*TILE_PX and
// MAP_ROWS*TILE_PX must not exceed 256, and MAP_COLS*MAP_ROWS must fit 9 bits.
module tilemap_scheduler #(
  parameter int         MAP_COLS  = 20,
  parameter int         MAP_ROWS  = 15,
  parameter int         TILE_PX   = 8,
  parameter logic [7:0] SKIP_TILE = 8'hFF
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic                abort,
  tilemap_scheduler_if.master bus,
  output logic                busy,
  output logic                done,
  output logic [8:0]          tiles_drawn
);

  localparam int         ACK_TIMEOUT = 4;
  localparam logic [7:0] LAST_COL    = 8'(MAP_COLS - 1);
  localparam logic [7:0] LAST_ROW    = 8'(MAP_ROWS - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_DATA,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE,
    ADVANCE,
    FINISH
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] col_q, col_d;
  logic [7:0] row_q, row_d;
  logic [7:0] tile_q, tile_d;
  logic [7:0] x_q, x_d;
  logic [7:0] y_q, y_d;
  logic [8:0] count_q, count_d;
  logic [2:0] ack_cnt_q, ack_cnt_d;

  // State and datapath registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      col_q     <= '0;
      row_q     <= '0;
      tile_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      count_q   <= '0;
      ack_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      tile_q    <= tile_d;
      x_q       <= x_d;
      y_q       <= y_d;
      count_q   <= count_d;
      ack_cnt_q <= ack_cnt_d;
    end
  end

  // Next-state logic: fetch, filter skip entries, issue, wait out the drawer, step.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    tile_d    = tile_q;
    x_d       = x_q;
    y_d       = y_q;
    count_d   = count_q;
    ack_cnt_d = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          col_d   = '0;
          row_d   = '0;
          count_d = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        state_d = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (bus.map_data == SKIP_TILE) begin
          state_d = ADVANCE;
        end else begin
          tile_d  = bus.map_data;
          x_d     = 8'(col_q * TILE_PX);
          y_d     = 8'(row_q * TILE_PX);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        count_d = count_q + 9'd1;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (bus.drawer_active || (ack_cnt_q == 3'(ACK_TIMEOUT - 1))) begin
          state_d = WAIT_DONE;
        end else begin
          ack_cnt_d = ack_cnt_q + 3'd1;
        end
      end
      WAIT_DONE: begin
        if (!bus.drawer_active) begin
          state_d = ADVANCE;
        end
      end
      ADVANCE: begin
        if (abort) begin
          state_d = FINISH;
        end else if (col_q < LAST_COL) begin
          col_d   = col_q + 8'd1;
          state_d = FETCH;
        end else if (row_q < LAST_ROW) begin
          col_d   = '0;
          row_d   = row_q + 8'd1;
          state_d = FETCH;
        end else begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.map_addr            = 9'(row_q * MAP_COLS + col_q);
  assign bus.drawer_tile_address = tile_q;
  assign bus.drawer_x            = x_q;
  assign bus.drawer_y            = y_q;
  assign bus.drawer_draw         = (state_q == ISSUE);
  assign busy                    = (state_q != IDLE);
  assign done                    = (state_q == FINISH);
  assign tiles_drawn             = count_q;

endmodule

// File: tb/tb_tilemap_scheduler.sv
// Self-checking bench for tilemap_scheduler: a map RAM model, a tile drawer
// model, and a scoreboard of expected draws built straight from the map.
module tb_tilemap_scheduler;

  localparam int COLS  = 20;
  localparam int ROWS  = 15;
  localparam int TILES = COLS * ROWS;

  typedef struct packed {
    logic [7:0] tile;
    logic [7:0] x;
    logic [7:0] y;
  } draw_t;

  logic       clk;
  logic       resetn;
  logic       start;
  logic       abort;
  logic       busy;
  logic       done;
  logic [8:0] tilesDrawn;

  tilemap_scheduler_if ifc ();

  tilemap_scheduler #(
    .MAP_COLS (COLS),
    .MAP_ROWS (ROWS),
    .TILE_PX  (8),
    .SKIP_TILE(8'hFF)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .abort      (abort),
    .bus        (ifc),
    .busy       (busy),
    .done       (done),
    .tiles_drawn(tilesDrawn)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:TILES-1];
  draw_t      expQ[$];
  int         expDone[$];

  int    drawsSeen   = 0;
  int    doneSeen    = 0;
  int    drawsInPass = 0;
  int    cyc         = 0;
  int    lastDrawCyc = 0;
  int    skipHits    = 0;
  bit    pendingCount = 0;
  bit    prevDraw    = 0;
  bit    haveLast    = 0;
  bit    drawerMode  = 1;
  draw_t lastDraw;
  logic [7:0] firstX, firstY;

  // Free-running clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous map RAM: data for an address appears one cycle later.
  always @(posedge clk) begin
    ifc.map_data <= mem[ifc.map_addr];
  end

  // Tile drawer: busy for 3 cycles after each draw, or silent when muted.
  initial begin
    ifc.drawer_active = 1'b0;
    forever begin
      @(negedge clk);
      if (ifc.drawer_draw && drawerMode) begin
        @(posedge clk);
        #1 ifc.drawer_active = 1'b1;
        repeat (3) @(posedge clk);
        #1 ifc.drawer_active = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Scoreboard: every draw is popped from the model, and each done closes a pass.
  always @(negedge clk) begin
    cyc++;
    if (!resetn) begin
      haveLast     = 0;
      pendingCount = 0;
      drawsInPass  = 0;
      prevDraw     = 0;
    end else begin
      if (pendingCount) begin
        checkOutput("tiles_drawn_step", 32'(tilesDrawn), drawsInPass);
        pendingCount = 0;
      end
      if (ifc.drawer_draw) begin
        checkOutput("draw_single_cycle", 32'(prevDraw), 0);
        checkOutput("draw_while_busy", 32'(busy), 1);
        checkOutput("draw_expected", 32'(expQ.size() != 0), 1);
        if (expQ.size() != 0) begin
          draw_t e;
          e = expQ.pop_front();
          checkOutput("draw_tile", 32'(ifc.drawer_tile_address), 32'(e.tile));
          checkOutput("draw_x", 32'(ifc.drawer_x), 32'(e.x));
          checkOutput("draw_y", 32'(ifc.drawer_y), 32'(e.y));
        end
        if (!drawerMode && drawsInPass > 0) begin
          checkOutput("timeout_gap_min", 32'(cyc - lastDrawCyc >= 7), 1);
          checkOutput("timeout_gap_max", 32'(cyc - lastDrawCyc <= 12), 1);
        end
        if (drawsInPass == 0) begin
          firstX = ifc.drawer_x;
          firstY = ifc.drawer_y;
        end
        if ((ifc.drawer_x == 8'd0 && ifc.drawer_y == 8'd0) ||
            (ifc.drawer_x == 8'd8 && ifc.drawer_y == 8'd8)) skipHits++;
        lastDraw     = '{ifc.drawer_tile_address, ifc.drawer_x, ifc.drawer_y};
        haveLast     = 1;
        lastDrawCyc  = cyc;
        drawsInPass++;
        drawsSeen++;
        pendingCount = 1;
      end else if (haveLast) begin
        checkOutput("fields_stable",
                    32'({ifc.drawer_tile_address, ifc.drawer_x, ifc.drawer_y}), 32'(lastDraw));
      end
      prevDraw = ifc.drawer_draw;
      if (done) begin
        checkOutput("done_expected", 32'(expDone.size() != 0), 1);
        if (expDone.size() != 0) begin
          checkOutput("done_tiles_drawn", 32'(tilesDrawn), expDone.pop_front());
        end
        drawsInPass = 0;
        doneSeen++;
      end
    end
  end

  task automatic fillMap(input logic [7:0] v);
    for (int i = 0; i < TILES; i++) mem[i] = v;
  endtask

  // Model of one pass: every non-skip entry in scan order, optionally cut short.
  task automatic buildExpected(input int limit);
    int n = 0;
    for (int idx = 0; idx < TILES; idx++) begin
      if (mem[idx] != 8'hFF && (limit < 0 || n < limit)) begin
        expQ.push_back('{mem[idx], 8'((idx % COLS) * 8), 8'((idx / COLS) * 8)});
        n++;
      end
    end
    expDone.push_back(n);
  endtask

  task automatic applyStimulus(input logic s, input logic a);
    @(posedge clk);
    #1;
    start = s;
    abort = a;
  endtask

  task automatic waitDone(input int target, input int maxCycles, input string name);
    int n = 0;
    while (doneSeen < target && n < maxCycles) begin
      @(posedge clk);
      n++;
    end
    checkOutput(name, doneSeen, target);
  endtask

  task automatic waitDraws(input int target, input int maxCycles, input string name);
    int n = 0;
    while (drawsSeen < target && n < maxCycles) begin
      @(posedge clk);
      n++;
    end
    checkOutput(name, drawsSeen, target);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_done"}, 32'(done), 0);
    checkOutput({tag, "_draw"}, 32'(ifc.drawer_draw), 0);
    checkOutput({tag, "_tiles_drawn"}, 32'(tilesDrawn), 0);
    checkOutput({tag, "_map_addr"}, 32'(ifc.map_addr), 0);
    checkOutput({tag, "_tile"}, 32'(ifc.drawer_tile_address), 0);
    checkOutput({tag, "_x"}, 32'(ifc.drawer_x), 0);
    checkOutput({tag, "_y"}, 32'(ifc.drawer_y), 0);
  endtask

  // Runaway guard so the bench always terminates.
  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit, got %0d checks", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    int baseDraws;
    int baseDone;
    resetn = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    fillMap(8'h05);
    repeat (3) @(posedge clk);
    #1 checkAllZero("reset");
    resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1 checkOutput("idle_after_reset", 32'(busy), 0);

    $display("[TB] full pass");
    buildExpected(-1);
    baseDraws = drawsSeen;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    waitDone(1, 4000, "full_done");
    checkOutput("full_draw_count", drawsSeen - baseDraws, 300);
    checkOutput("full_last_x", 32'(lastDraw.x), 152);
    checkOutput("full_last_y", 32'(lastDraw.y), 112);
    repeat (3) @(posedge clk);
    #1 checkOutput("full_tiles_held", 32'(tilesDrawn), 300);
    checkOutput("full_idle", 32'(busy), 0);
    checkOutput("full_single_done", doneSeen, 1);

    $display("[TB] skip entries");
    fillMap(8'h01);
    mem[0]  = 8'hFF;
    mem[21] = 8'hFF;
    buildExpected(-1);
    skipHits = 0;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    waitDone(2, 4000, "skip_done");
    #1 checkOutput("skip_no_hits", skipHits, 0);
    checkOutput("skip_tiles_drawn", 32'(tilesDrawn), 298);

    $display("[TB] abort during third tile");
    fillMap(8'h05);
    buildExpected(3);
    baseDraws = drawsSeen;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    waitDraws(baseDraws + 3, 200, "abort_three_draws");
    @(posedge clk);
    #1 abort = 1'b1;
    waitDone(3, 200, "abort_done");
    #1 abort = 1'b0;
    checkOutput("abort_tiles_drawn", 32'(tilesDrawn), 3);
    repeat (10) @(posedge clk);
    #1 checkOutput("abort_no_fourth", drawsSeen - baseDraws, 3);

    $display("[TB] abort alone in idle, then start with abort");
    applyStimulus(1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1 checkOutput("idle_abort_ignored", 32'(busy), 0);
    buildExpected(1);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    waitDone(4, 200, "start_abort_done");
    #1 abort = 1'b0;
    checkOutput("start_abort_tiles", 32'(tilesDrawn), 1);

    $display("[TB] ack timeout");
    drawerMode = 0;
    buildExpected(-1);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    waitDone(5, 6000, "timeout_done");
    #1 checkOutput("timeout_tiles_drawn", 32'(tilesDrawn), 300);
    drawerMode = 1;

    $display("[TB] reset mid-pass");
    buildExpected(-1);
    baseDraws = drawsSeen;
    baseDone  = doneSeen;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    waitDraws(baseDraws + 10, 400, "reset_ten_draws");
    @(posedge clk);
    #1 resetn = 1'b0;
    expQ.delete();
    expDone.delete();
    #1 checkAllZero("midreset");
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (20) @(posedge clk);
    #1 checkOutput("postreset_idle", 32'(busy), 0);
    checkOutput("postreset_no_draw", drawsSeen - baseDraws, 10);
    checkOutput("postreset_no_done", doneSeen - baseDone, 0);

    $display("[TB] back-to-back passes");
    buildExpected(-1);
    buildExpected(-1);
    baseDraws = drawsSeen;
    baseDone  = doneSeen;
    applyStimulus(1'b1, 1'b0);
    waitDone(baseDone + 1, 4000, "b2b_first_done");
    waitDraws(baseDraws + 301, 50, "b2b_second_start");
    #1 checkOutput("b2b_first_x", 32'(firstX), 0);
    checkOutput("b2b_first_y", 32'(firstY), 0);
    checkOutput("b2b_tiles_restart", 32'(tilesDrawn), 1);
    start = 1'b0;
    waitDone(baseDone + 2, 4000, "b2b_second_done");
    #1 checkOutput("b2b_tiles_drawn", 32'(tilesDrawn), 300);
    repeat (5) @(posedge clk);
    #1 checkOutput("b2b_idle", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
